seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Output-side counterpart of the front-panel button controller. It shows the two user-set counters (PLL setting CNT1, sequence setting CNT2) on a 4-digit multiplexed 7-segment display.
- Converts each 8-bit binary value to BCD with a sequential shift-add-3 (double-dabble) engine and latches the results atomically.
- Scans the digits with a programmable refresh divider and a one-cycle anti-ghost guard.
- Sits between the button controller outputs and the board LED pins.

Parameters:
- DBW, 12, width of the refresh divider.
- RV, 1'b1, inactive level of SEG/DP/DIG pins (1 = active-low display).
- LZB, 1'b1, blank the tens digit when it is zero.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- DIV  input  DBW  cycles per digit minus 1 (e.g. 2499); static while running.
- CNT1  input  8  binary value shown on digits 3..2.
- CNT2  input  8  binary value shown on digits 1..0.
- BLANK  input  1  1 = all digits dark.
- SEG  output  7  segments a..g (bit0 = a); RV = off.
- DP  output  1  decimal point; RV = off.
- DIG  output  4  digit enables, one-hot active; RV = off.

Behaviour:
- Reset (async, RST=1):
  - SEG = {7{RV}}, DP = RV, DIG = {4{RV}}.
  - Divider = 0, digit index = 3, FSM = IDLE.
  - Snapshots = 0; display registers hold the image of value 0: tens blank if LZB, units "0".
  - Reset mid-conversion aborts the conversion; no partial result is ever visible.
- Clock: one clock; everything is clocked on the CLK rising edge.
- Refresh divider:
  - Counts 0..DIV, then wraps to 0. tick = (count == DIV).
  - On tick the digit index decrements 3→2→1→0→3.
  - DIV = 0 is legal: the index advances every cycle.
- Outputs are registered.
  - In the cycle after a tick (guard cycle): DIG = all inactive, SEG/DP = inactive.
  - Otherwise: DIG drives the active level on bit [index] only; SEG and DP show that digit.
  - When BLANK = 1: DIG is all inactive; SEG and DP are inactive.
- Digit map:
  - Digit 3 = CNT1 tens.
  - Digit 2 = CNT1 units, with DP lit.
  - Digit 1 = CNT2 tens.
  - Digit 0 = CNT2 units.
- Value rule (per counter):
  - 0..99 → tens/units. With LZB=1 a zero tens digit is blanked (all segments off).
  - 100..255 → both digits show "-" (segment g only). The DP rule still applies.
- Converter FSM, states IDLE, SHIFT, LOAD:
  - IDLE: if {CNT1, CNT2} ≠ snapshot, capture both inputs into the snapshot, clear the BCD work registers, set bit count = 0, go to SHIFT.
  - SHIFT: 8 cycles. Each cycle adds 3 to any BCD nibble ≥ 5, then shifts in the next MSB. Both converters run in parallel. After the 8th cycle go to LOAD.
  - LOAD: compute the display codes for all four digits, write them in one cycle, return to IDLE.
  - Latency: a change at the input is visible in the display registers exactly 10 cycles later. SEG reflects it on the next scan of that digit.
  - Inputs changing during SHIFT/LOAD are ignored. The comparison in IDLE picks up the newest value afterwards; no update is lost, and intermediate values may be skipped.
  - Both counters changing in the same cycle produce one conversion.
- Arithmetic: BCD work register 12 bits (hundreds, tens, units). Hundreds ≠ 0 selects the dash rule.
- Segment decode: standard 0-9 hex patterns; codes 10-15 never occur. The decode output is inverted when RV = 1.

Decomposition:
- Shared package seg7_pkg holds:
  - the 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high form);
  - the FSM state encodings ST_IDLE, ST_SHIFT, ST_LOAD;
  - the digit-index constants.
- One sub-module, bin2bcd8: an 8-bit iterative double-dabble engine.
  - Ports: start, busy/done, bin[7:0], bcd[11:0].
  - Instantiated twice, both driven by the shared FSM's start.

Test Plan:
- Reset with RV=1, DIV=3, CNT1=CNT2=0.
  - During reset: SEG=7'h7F, DIG=4'hF.
  - After release: digits rotate 3,2,1,0 every 4 cycles, each preceded by a 1-cycle all-off guard.
  - Digit 0 SEG pattern = "0"; digit 1 blank.
- CNT1=42 applied at cycle T.
  - Display register changes at T+10, not earlier.
  - Digit 3 = "4"; digit 2 = "2" with DP low.
- CNT2=7 with LZB=1 → digit 1 all off, digit 0 = "7". CNT2=100 → digits 1 and 0 = "-" (SEG=7'h3F for RV=1).
- CNT1 goes 5→6→9 on consecutive cycles mid-conversion → final display "09" with the tens digit blanked. No "06" is left stuck after the second conversion completes.
- BLANK=1 for 20 cycles → DIG=4'hF throughout. On release, scanning resumes at the current index with no phase reset.
- Assert RST during SHIFT → outputs go inactive at once. After release the display shows 0 until the inputs differ from the zero snapshot, and then updates correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_scan display driver.
//   - Segment patterns in active-high form, bit0 = segment a ... bit6 = segment g.
//   - Converter FSM state encoding.
//   - Digit index constants (digit 3 is the leftmost, scanned first).
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam logic [1:0] DIG_IDX_0 = 2'd0;
  localparam logic [1:0] DIG_IDX_1 = 2'd1;
  localparam logic [1:0] DIG_IDX_2 = 2'd2;
  localparam logic [1:0] DIG_IDX_3 = 2'd3;

  // BCD digit to active-high segment pattern. Codes 10..15 cannot come out
  // of an 8-bit conversion; they decode to dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to BCD converter (shift-add-3 / double dabble).
//   clk, rst : clock, asynchronous active-high reset
//   start    : loads bin and clears the work register (one cycle)
//   bin      : binary value, sampled only in the start cycle
//   done     : high during the 8th shift cycle; bcd is final after that edge
//   bcd      : {hundreds, tens, units}
module bin2bcd8
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  sh_q, sh_d;
  logic [11:0] work_q, work_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [11:0] adj;

  always_comb begin
    // Add 3 to any nibble >= 5 so that it carries correctly after the shift.
    adj = work_q;
    if (adj[3:0]  >= 4'd5) adj[3:0]  = adj[3:0]  + 4'd3;
    if (adj[7:4]  >= 4'd5) adj[7:4]  = adj[7:4]  + 4'd3;
    if (adj[11:8] >= 4'd5) adj[11:8] = adj[11:8] + 4'd3;

    sh_d   = sh_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      sh_d   = bin;
      work_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      work_d = {adj[10:0], sh_q[7]};
      sh_d   = {sh_q[6:0], 1'b0};
      cnt_d  = cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == 3'd7);
  assign bcd  = work_q;

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver for two 8-bit counters.
//   CLK, RST  : clock, asynchronous active-high reset
//   DIV       : cycles per digit minus 1 (static while running)
//   CNT1      : shown on digits 3 (tens) and 2 (units, decimal point lit)
//   CNT2      : shown on digits 1 (tens) and 0 (units)
//   BLANK     : 1 = display dark
//   SEG/DP/DIG: registered pin drives, RV is the inactive level
// Values above 99 show "--". Conversions run only when the inputs differ
// from the last captured snapshot, and all four digit images update in a
// single cycle so a half-converted value is never displayed.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int   DBW = 12,
  parameter logic RV  = 1'b1,
  parameter logic LZB = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [DBW-1:0] DIV,
  input  logic [7:0]     CNT1,
  input  logic [7:0]     CNT2,
  input  logic           BLANK,
  output logic [6:0]     SEG,
  output logic           DP,
  output logic [3:0]     DIG
);

  localparam logic [6:0] TENS_ZERO = LZB ? SEG_OFF : SEG_0;

  conv_state_t    state_q, state_d;
  logic [7:0]     snap1_q, snap1_d, snap2_q, snap2_d;
  logic [6:0]     disp_q [4];
  logic [6:0]     disp_d [4];
  logic [DBW-1:0] div_q, div_d;
  logic [1:0]     idx_q, idx_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [3:0]     dig_q, dig_d;

  logic           start;
  logic           tick;
  logic [1:0]     done_w;
  logic [7:0]     bin_w [2];
  logic [11:0]    bcd_w [2];
  logic [13:0]    pair1, pair2;

  assign bin_w[0] = CNT1;
  assign bin_w[1] = CNT2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_conv
      bin2bcd8 u_conv (
        .clk  (CLK),
        .rst  (RST),
        .start(start),
        .bin  (bin_w[gi]),
        .done (done_w[gi]),
        .bcd  (bcd_w[gi])
      );
    end
  endgenerate

  // {tens image, units image} for one counter.
  function automatic logic [13:0] pair_code(input logic [11:0] bcd);
    logic [6:0] tens;
    if (bcd[11:8] != 4'd0) return {SEG_DASH, SEG_DASH};
    tens = (LZB && bcd[7:4] == 4'd0) ? SEG_OFF : seg_decode(bcd[7:4]);
    return {tens, seg_decode(bcd[3:0])};
  endfunction

  assign start = (state_q == ST_IDLE) && ({CNT1, CNT2} != {snap1_q, snap2_q});
  assign pair1 = pair_code(bcd_w[0]);
  assign pair2 = pair_code(bcd_w[1]);

  // Converter sequencing: the converters are started by the same pulse that
  // captures the snapshot, so both see the same input sample.
  always_comb begin
    state_d = state_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    disp_d  = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap1_d = CNT1;
          snap2_d = CNT2;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (&done_w) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        disp_d[3] = pair1[13:7];
        disp_d[2] = pair1[6:0];
        disp_d[1] = pair2[13:7];
        disp_d[0] = pair2[6:0];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan: the output register goes dark on the tick edge, which gives one
  // guard cycle while the digit enable moves to the next position.
  always_comb begin
    tick  = (div_q == DIV);
    div_d = tick ? '0 : div_q + DBW'(1);
    idx_d = tick ? idx_q - 2'd1 : idx_q;
    seg_d = {7{RV}};
    dp_d  = RV;
    dig_d = {4{RV}};
    if (!tick && !BLANK) begin
      seg_d        = disp_q[idx_q] ^ {7{RV}};
      dp_d         = (idx_q == DIG_IDX_2) ? ~RV : RV;
      dig_d[idx_q] = ~RV;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      snap1_q   <= '0;
      snap2_q   <= '0;
      disp_q[3] <= TENS_ZERO;
      disp_q[2] <= SEG_0;
      disp_q[1] <= TENS_ZERO;
      disp_q[0] <= SEG_0;
      div_q     <= '0;
      idx_q     <= DIG_IDX_3;
      seg_q     <= {7{RV}};
      dp_q      <= RV;
      dig_q     <= {4{RV}};
    end else begin
      state_q <= state_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
      disp_q  <= disp_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  assign SEG = seg_q;
  assign DP  = dp_q;
  assign DIG = dig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (RV=1, LZB=1). The stimulus task predicts,
// from the display rules, what the pins must show after each clock edge and
// queues it; a monitor compares the pins on every falling edge.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] div;
  logic [7:0]  cnt1, cnt2;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;

  seg7_scan dut (
    .CLK  (clk),
    .RST  (rst),
    .DIV  (div),
    .CNT1 (cnt1),
    .CNT2 (cnt2),
    .BLANK(blank),
    .SEG  (seg),
    .DP   (dp),
    .DIG  (dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (values, not encodings).
  logic [6:0] pat [10];
  int  k;                        // edges since reset release
  int  snap1, snap2;             // last captured inputs
  int  shown1, shown2;           // values currently in the display image
  int  pend1, pend2, load_edge;
  bit  busy;
  bit  rst_prev = 1'b0;
  int  last_c1 = -1, last_c2 = -1;
  bit  last_b = 1'b0, last_r = 1'b0;

  function automatic logic [6:0] digit_code(input int v, input bit tens);
    if (v > 99) return 7'h40;
    if (tens) return (v / 10 == 0) ? 7'h00 : pat[v / 10];
    return pat[v % 10];
  endfunction

  task automatic step(input bit r, input int c1, input int c2, input bit b);
    exp_t e;
    exp_t dropped;
    int   p;
    int   d;
    logic [6:0] code;
    rst   = r;
    cnt1  = c1[7:0];
    cnt2  = c2[7:0];
    blank = b;
    if (r != last_r || c1 != last_c1 || c2 != last_c2 || b != last_b)
      $display("txn cyc=%0d rst=%0d cnt1=%0d cnt2=%0d blank=%0d div=%0d", cyc, r, c1, c2, b, div);
    last_r = r; last_c1 = c1; last_c2 = c2; last_b = b;

    // Asynchronous reset: the pins must be dark before the next edge, so the
    // prediction queued for this cycle is replaced.
    if (r && !rst_prev && exp_q.size() > 0) begin
      dropped = exp_q.pop_back();
      e.cyc = dropped.cyc;
      e.seg = 7'h7F; e.dp = 1'b1; e.dig = 4'hF;
      exp_q.push_back(e);
    end
    rst_prev = r;

    e.cyc = cyc + 1;
    e.seg = 7'h7F; e.dp = 1'b1; e.dig = 4'hF;
    if (r) begin
      k = 0; snap1 = 0; snap2 = 0; shown1 = 0; shown2 = 0; busy = 1'b0;
    end else begin
      k++;
      p = int'(div) + 1;
      if ((k % p) != 0 && !b) begin
        d = 3 - (((k - 1) / p) % 4);
        case (d)
          3:       code = digit_code(shown1, 1'b1);
          2:       code = digit_code(shown1, 1'b0);
          1:       code = digit_code(shown2, 1'b1);
          default: code = digit_code(shown2, 1'b0);
        endcase
        e.seg = ~code;
        e.dp  = (d == 2) ? 1'b0 : 1'b1;
        e.dig = 4'hF;
        e.dig[d] = 1'b0;
      end
      // Conversion: captured when idle and different, shown 9 edges later.
      if (busy) begin
        if (k == load_edge) begin
          shown1 = pend1; shown2 = pend2; busy = 1'b0;
        end
      end else if (c1 != snap1 || c2 != snap2) begin
        snap1 = c1; snap2 = c2; pend1 = c1; pend2 = c2;
        load_edge = k + 9; busy = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (seg !== e.seg || dp !== e.dp || dig !== e.dig) begin
          errors++;
          $display("FAIL pins cyc=%0d got seg=%h dp=%b dig=%h expected seg=%h dp=%b dig=%h",
                   e.cyc, seg, dp, dig, e.seg, e.dp, e.dig);
        end
      end
    end
  end

  initial begin
    int c1, c2;
    bit b;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    div = 12'd3;
    rst = 1'b1; cnt1 = 8'd0; cnt2 = 8'd0; blank = 1'b0;

    repeat (3) step(1, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0);
    repeat (30) step(0, 42, 0, 0);
    repeat (30) step(0, 42, 7, 0);
    repeat (30) step(0, 42, 100, 0);
    step(0, 5, 100, 0);
    step(0, 6, 100, 0);
    repeat (40) step(0, 9, 100, 0);
    repeat (20) step(0, 9, 100, 1);
    repeat (30) step(0, 9, 100, 0);

    c1 = 9; c2 = 100; b = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) c1 = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 130);
      if ($urandom_range(0, 7) == 0) c2 = $urandom_range(0, 130);
      if ($urandom_range(0, 39) == 0) b = ~b;
      step(0, c1, c2, b);
    end

    // Reset in the middle of a conversion.
    repeat (15) step(0, 0, 0, 0);
    step(0, 77, 12, 0);
    repeat (4) step(0, 77, 12, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0);
    repeat (40) step(0, 33, 58, 0);

    // Other refresh rates, including DIV = 0.
    for (int ph = 0; ph < 3; ph++) begin
      div = (ph == 0) ? 12'd0 : (ph == 1) ? 12'd1 : 12'd6;
      repeat (2) step(1, 0, 0, 0);
      c1 = 0; c2 = 0; b = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 9) == 0) c1 = $urandom_range(0, 255);
        if ($urandom_range(0, 9) == 0) c2 = $urandom_range(0, 120);
        if ($urandom_range(0, 49) == 0) b = ~b;
        step(0, c1, c2, b);
      end
    end

    step(0, c1, c2, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
